enc_input_stager: RTL and testbench
===================================

ENC_INPUT_STAGER -- requirements
Module: enc_input_stager

Interface
REQ-001 SHALL have parameter N, default 8, meaning data and key width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, meaning data FIFO entries; a power of two, at least 2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port key_load, input, 1 bit: request to start a new serial key load.
REQ-006 SHALL have port key_bit, input, 1 bit: serial key data, sent MSB first.
REQ-007 SHALL have port key_bit_valid, input, 1 bit: key_bit is valid in this cycle.
REQ-008 SHALL have port data_in, input, N bits: plaintext word from upstream.
REQ-009 SHALL have port in_valid, input, 1 bit: data_in is valid.
REQ-010 SHALL have port in_ready, output, 1 bit: the stager accepts data_in in this cycle.
REQ-011 SHALL have port data_out, output, N bits: FIFO head word, driven to the encryption stage.
REQ-012 SHALL have port key, output, N bits: committed key, driven to the encryption stage.
REQ-013 SHALL have port out_valid, output, 1 bit: data_out is valid.
REQ-014 SHALL have port out_ready, input, 1 bit: downstream consumes data_out.
REQ-015 SHALL have port key_valid, output, 1 bit: a committed key exists (state ACTIVE).

Function
REQ-016 SHALL implement FSM states NO_KEY, KEY_SHIFT, DRAIN and ACTIVE.
REQ-017 SHALL go NO_KEY->KEY_SHIFT on key_load and clear the bit counter.
REQ-018 SHALL, in KEY_SHIFT, shift key_bit into a shadow register on each key_bit_valid.
REQ-019 SHALL, on the Nth valid bit, copy the shadow register to key and go to ACTIVE; key is visible on the next cycle.
REQ-020 SHALL restart the bit counter at 0 on key_load in KEY_SHIFT; an in-cycle key_bit_valid is then taken as bit 0.
REQ-021 SHALL ignore key_bit_valid in NO_KEY, DRAIN and ACTIVE.
REQ-022 SHALL go ACTIVE->DRAIN on key_load when the FIFO is non-empty, and ACTIVE->KEY_SHIFT when it is empty.
REQ-023 SHALL go DRAIN->KEY_SHIFT on the cycle after the FIFO becomes empty.
REQ-024 SHALL hold key stable, at its old value, in DRAIN and KEY_SHIFT, so queued words are encrypted with the key current at push time.
REQ-025 SHALL drive in_ready = (state==ACTIVE) && !full && !key_load.
REQ-026 SHALL push on in_valid && in_ready, and pop on out_valid && out_ready.
REQ-027 SHALL drive out_valid = !empty, in every state.
REQ-028 SHALL, on simultaneous push and pop, leave the occupancy unchanged; when full, in_ready=0, so no push occurs.
REQ-029 SHALL have no bypass: a word pushed into an empty FIFO appears on data_out one cycle later.
REQ-030 SHALL use read/write pointers that wrap modulo DEPTH, with occupancy held in a count of log2(DEPTH)+1 bits.
REQ-031 SHALL drive data_out from registered FIFO storage only; it is X-free after reset.

Reset
REQ-032 SHALL, while rst_n=0, set state=NO_KEY, key=0, shadow=0, count=0, pointers=0, in_ready=0, out_valid=0, key_valid=0 and data_out=0.
REQ-033 SHALL, on a reset mid-key-load or with a non-empty FIFO, discard all contents; no partial key is ever committed.

Structure
REQ-034 SHALL place the FSM state enum and the default N/DEPTH constants in the shared package enc_pkg.
REQ-035 SHALL implement the FIFO as one sub-module, enc_sync_fifo, parameterised by N and DEPTH.

Verification
REQ-036 SHALL cover: after reset, serial bits 1,1,0,0,1,1,0,0 -> key=8'hCC and key_valid=1 one cycle after the 8th bit.
REQ-037 SHALL cover: with key set and out_ready=0, push 8'hAA,8'h55,8'h00,8'hFF -> in_ready=0 after the 4th push; a 5th word is held.
REQ-038 SHALL cover: then out_ready=1 -> data_out AA,55,00,FF in order, out_valid=0 after the 4th pop; in_ready reasserts.
REQ-039 SHALL cover: key_load with 2 words queued -> DRAIN, key stays 8'hCC until both pop, then shift of 00110011 -> key=8'h33.
REQ-040 SHALL cover: rst_n low after 5 key bits -> key=0, key_valid=0, in_ready=0; a full 8-bit reload then succeeds.
REQ-041 SHALL cover: steady push+pop every cycle at occupancy 1 for 10 cycles -> occupancy stays 1 and the sequence is preserved.

Source files
------------

// File: rtl/enc_pkg.sv
// enc_pkg: shared state encoding and default sizing for the encryption input stager
package enc_pkg;
    localparam int ENC_N = 8;
    localparam int ENC_DEPTH = 4;
    typedef enum logic [1:0] {NO_KEY, KEY_SHIFT, DRAIN, ACTIVE} enc_state_t;
endpackage

// File: rtl/enc_sync_fifo.sv
// enc_sync_fifo: registered-storage FIFO with no bypass; reads come straight from storage
module enc_sync_fifo
    import enc_pkg::*;
#(
    parameter int N = ENC_N,
    parameter int DEPTH = ENC_DEPTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [N-1:0] wdata,
    output logic [N-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    logic [N-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic do_push, do_pop;
    assign do_push = push && !full;
    assign do_pop = pop && !empty;
    assign full = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign rdata = mem[rd_ptr];
    // storage is reset too so the head word is never X
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/enc_input_stager.sv
// enc_input_stager: serial key loader plus plaintext FIFO; a key change waits for queued words to drain
module enc_input_stager
    import enc_pkg::*;
#(
    parameter int N = ENC_N,
    parameter int DEPTH = ENC_DEPTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_load,
    input  logic         key_bit,
    input  logic         key_bit_valid,
    input  logic [N-1:0] data_in,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] data_out,
    output logic [N-1:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         key_valid
);
    localparam int CW = $clog2(N) + 1;
    enc_state_t state;
    logic [N-1:0] shadow;
    logic [N-1:0] shifted;
    logic [CW-1:0] cnt;
    logic full, empty;
    assign in_ready = state == ACTIVE && !full && !key_load;
    assign out_valid = !empty;
    assign key_valid = state == ACTIVE;
    assign shifted = {shadow[N-2:0], key_bit};
    enc_sync_fifo #(.N(N), .DEPTH(DEPTH)) u_fifo (
        .clk(clk),
        .rst_n(rst_n),
        .push(in_valid && in_ready),
        .pop(out_valid && out_ready),
        .wdata(data_in),
        .rdata(data_out),
        .full(full),
        .empty(empty)
    );
    // key only changes on the final bit, so DRAIN and KEY_SHIFT keep the old key
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= NO_KEY;
            key <= '0;
            shadow <= '0;
            cnt <= '0;
        end else begin
            case (state)
                NO_KEY: if (key_load) begin
                    state <= KEY_SHIFT;
                    cnt <= '0;
                end
                KEY_SHIFT: if (key_load) begin
                    cnt <= CW'(key_bit_valid);
                    if (key_bit_valid) shadow <= shifted;
                end else if (key_bit_valid) begin
                    shadow <= shifted;
                    if (cnt == CW'(N - 1)) begin
                        key <= shifted;
                        state <= ACTIVE;
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DRAIN: if (empty) begin
                    state <= KEY_SHIFT;
                    cnt <= '0;
                end
                ACTIVE: if (key_load) begin
                    state <= empty ? KEY_SHIFT : DRAIN;
                    cnt <= '0;
                end
                default: state <= NO_KEY;
            endcase
        end
    end
endmodule

// File: tb/tb_enc_input_stager.sv
// tb_enc_input_stager: directed sequence with a data scoreboard checked on every pop
module tb_enc_input_stager;
    localparam int N = 8;
    localparam int DEPTH = 4;
    logic clk = 0, rst_n = 0, key_load = 0, key_bit = 0, key_bit_valid = 0;
    logic in_valid = 0, out_ready = 0;
    logic [N-1:0] data_in = '0;
    logic in_ready, out_valid, key_valid;
    logic [N-1:0] data_out, key;
    int tests = 0, fails = 0;
    logic [N-1:0] sb [$];

    always #5 clk = ~clk;

    enc_input_stager #(.N(N), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .key_load(key_load), .key_bit(key_bit),
        .key_bit_valid(key_bit_valid), .data_in(data_in), .in_valid(in_valid),
        .in_ready(in_ready), .data_out(data_out), .key(key), .out_valid(out_valid),
        .out_ready(out_ready), .key_valid(key_valid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // one clock: sample the handshake mid-low-phase, update the scoreboard, return at the next negedge
    task automatic step();
        logic [N-1:0] head;
        #2;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $error("FAIL pop_unexpected: got %0h expected no pop", data_out);
            end else begin
                head = sb.pop_front();
                chk("data_out", {24'h0, data_out}, {24'h0, head});
            end
        end
        if (in_valid && in_ready) sb.push_back(data_in);
        @(negedge clk);
    endtask

    task automatic send_bits(input logic [N-1:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            key_bit = v[N-1-i];
            key_bit_valid = 1;
            step();
        end
        key_bit_valid = 0;
    endtask

    task automatic load_key(input logic [N-1:0] v, input logic [N-1:0] old_key);
        send_bits(v, N - 1);
        #1 chk("key_before_last_bit", {24'h0, key}, {24'h0, old_key});
        chk("key_valid_before_last_bit", {31'h0, key_valid}, 0);
        key_bit = v[0];
        key_bit_valid = 1;
        step();
        key_bit_valid = 0;
        #1 chk("key_committed", {24'h0, key}, {24'h0, v});
        chk("key_valid_committed", {31'h0, key_valid}, 1);
    endtask

    initial begin
        @(negedge clk);
        #1 chk("rst_key", {24'h0, key}, 0);
        chk("rst_key_valid", {31'h0, key_valid}, 0);
        chk("rst_in_ready", {31'h0, in_ready}, 0);
        chk("rst_out_valid", {31'h0, out_valid}, 0);
        chk("rst_data_out", {24'h0, data_out}, 0);
        @(negedge clk);
        rst_n = 1;
        key_load = 1;
        step();
        key_load = 0;
        load_key(8'hCC, 8'h00);

        in_valid = 1;
        foreach (sb[i]) ;
        data_in = 8'hAA; step();
        data_in = 8'h55; step();
        data_in = 8'h00; step();
        data_in = 8'hFF; step();
        #1 chk("in_ready_full", {31'h0, in_ready}, 0);
        chk("head_aa", {24'h0, data_out}, 32'hAA);
        data_in = 8'h11;
        step();
        step();
        #1 chk("held_in_ready", {31'h0, in_ready}, 0);
        chk("occupancy_full", {28'h0, dut.u_fifo.count}, DEPTH);
        in_valid = 0;
        out_ready = 1;
        repeat (4) step();
        #1 chk("drained_out_valid", {31'h0, out_valid}, 0);
        chk("in_ready_reasserts", {31'h0, in_ready}, 1);
        out_ready = 0;

        in_valid = 1;
        data_in = 8'h12; step();
        data_in = 8'h34; step();
        in_valid = 0;
        key_load = 1;
        #1 chk("in_ready_during_key_load", {31'h0, in_ready}, 0);
        step();
        key_load = 0;
        #1 chk("drain_key_valid", {31'h0, key_valid}, 0);
        chk("drain_key_held", {24'h0, key}, 32'hCC);
        out_ready = 1;
        step();
        #1 chk("drain_key_held_1", {24'h0, key}, 32'hCC);
        chk("drain_in_ready", {31'h0, in_ready}, 0);
        step();
        #1 chk("drain_empty", {31'h0, out_valid}, 0);
        chk("drain_key_held_2", {24'h0, key}, 32'hCC);
        key_bit = 1;
        key_bit_valid = 1;
        step();
        key_bit_valid = 0;
        out_ready = 0;
        load_key(8'h33, 8'hCC);

        in_valid = 1;
        data_in = 8'h77;
        step();
        in_valid = 0;
        #1 chk("queued_before_reset", {31'h0, out_valid}, 1);
        rst_n = 0;
        #1 chk("reset_flushes_fifo", {31'h0, out_valid}, 0);
        chk("reset_data_out", {24'h0, data_out}, 0);
        chk("reset_key", {24'h0, key}, 0);
        sb.delete();
        @(negedge clk);
        rst_n = 1;
        key_load = 1;
        step();
        key_load = 0;
        send_bits(8'hA5, 5);
        rst_n = 0;
        #1 chk("midload_key", {24'h0, key}, 0);
        chk("midload_key_valid", {31'h0, key_valid}, 0);
        chk("midload_in_ready", {31'h0, in_ready}, 0);
        @(negedge clk);
        rst_n = 1;
        key_load = 1;
        step();
        key_load = 0;
        load_key(8'hA5, 8'h00);

        in_valid = 1;
        data_in = 8'h01;
        step();
        out_ready = 1;
        for (int i = 0; i < 10; i++) begin
            data_in = N'(8'h10 + i);
            #1 chk("steady_occupancy", {28'h0, dut.u_fifo.count}, 1);
            chk("steady_in_ready", {31'h0, in_ready}, 1);
            step();
        end
        in_valid = 0;
        step();
        #1 chk("steady_drained", {31'h0, out_valid}, 0);
        chk("scoreboard_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no end of sequence expected finish");
        $fatal(1, "timeout");
    end
endmodule
